park_occupancy_ctrl: RTL and testbench

Sequential controller that owns the 8-space occupancy bitmap for the car park. It sequences each entry request through the space-allocation stage: it drives that stage's entry strobe and feeds it the bitmap as parking_capacity. It then consumes the returned park_number, marks that space occupied and times the entry gate. It also retires exits and keeps the free-space count and full flag.

---
 rtl/park_occupancy_ctrl.sv | 119 +++++++++++
 tb/tb_park_occupancy_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/park_occupancy_ctrl.sv
// Car park occupancy controller: owns the 8-space bitmap, sequences entries through
// the external allocation stage, times the entry gate and retires exits.
module park_occupancy_ctrl #(
  parameter int GATE_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_space,
  input  logic [2:0] park_number,
  output logic       entry_strobe,
  output logic [7:0] parking_capacity,
  output logic [2:0] assigned_space,
  output logic       gate_open,
  output logic       entry_reject,
  output logic       alloc_error,
  output logic       exit_error,
  output logic [3:0] free_count,
  output logic       full
);

  // state | meaning
  // IDLE  | waiting for a car at the entry, retiring exits
  // ALLOC | entry_strobe high, allocation stage returns park_number
  // GATE  | space granted, gate held open for GATE_CYCLES cycles
  typedef enum logic [1:0] {IDLE, ALLOC, GATE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [7:0]         bitmap_nxt;
  logic               alloc_hit;
  logic               alloc_ok;
  logic               exit_hit;
  logic               exit_ok;
  logic [3:0]         used;

  assign alloc_hit = parking_capacity[park_number];
  assign alloc_ok  = (state == ALLOC) && !alloc_hit;
  assign exit_hit  = parking_capacity[exit_space];
  assign exit_ok   = exit_req && exit_hit;

  // Both checks use the pre-edge bitmap, so a shared index is never both set and cleared.
  always_comb begin
    bitmap_nxt = parking_capacity;
    if (alloc_ok) bitmap_nxt[park_number] = 1'b1;
    if (exit_ok)  bitmap_nxt[exit_space]  = 1'b0;
  end

  always_comb begin
    used = 4'd0;
    for (int i = 0; i < 8; i++) used = used + {3'd0, parking_capacity[i]};
  end

  assign free_count = 4'd8 - used;
  assign full       = (parking_capacity == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      parking_capacity <= 8'h00;
      assigned_space   <= 3'd0;
      entry_strobe     <= 1'b0;
      gate_open        <= 1'b0;
      entry_reject     <= 1'b0;
      alloc_error      <= 1'b0;
      exit_error       <= 1'b0;
    end else begin
      parking_capacity <= bitmap_nxt;
      entry_reject     <= 1'b0;
      alloc_error      <= 1'b0;
      exit_error       <= exit_req && !exit_hit;
      case (state)
        IDLE: begin
          entry_strobe <= 1'b0;
          gate_open    <= 1'b0;
          // The cycle carrying a reject pulse is skipped so rejects repeat every 2 cycles.
          if (entry_req && !entry_reject) begin
            if (full) begin
              entry_reject <= 1'b1;
            end else begin
              state        <= ALLOC;
              entry_strobe <= 1'b1;
            end
          end
        end
        ALLOC: begin
          entry_strobe <= 1'b0;
          if (!alloc_hit) begin
            assigned_space <= park_number;
            timer          <= CNT_W'(GATE_CYCLES);
            gate_open      <= 1'b1;
            state          <= GATE;
          end else begin
            alloc_error <= 1'b1;
            state       <= IDLE;
          end
        end
        GATE: begin
          if (timer <= CNT_W'(1)) begin
            timer     <= '0;
            gate_open <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          entry_strobe <= 1'b0;
          gate_open    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_park_occupancy_ctrl.sv
// Directed bench for park_occupancy_ctrl: entry, full/reject, exit, error pulses,
// simultaneous exit+allocation and asynchronous reset during the gate.
module tb_park_occupancy_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_space = 3'd0;
  logic [2:0] park_number = 3'd0;
  logic       entry_strobe;
  logic [7:0] parking_capacity;
  logic [2:0] assigned_space;
  logic       gate_open;
  logic       entry_reject;
  logic       alloc_error;
  logic       exit_error;
  logic [3:0] free_count;
  logic       full;

  int errors = 0;
  int checks = 0;

  park_occupancy_ctrl #(.GATE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_space(exit_space), .park_number(park_number), .entry_strobe(entry_strobe),
    .parking_capacity(parking_capacity), .assigned_space(assigned_space),
    .gate_open(gate_open), .entry_reject(entry_reject), .alloc_error(alloc_error),
    .exit_error(exit_error), .free_count(free_count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_gate_close(input string tag);
    int n = 0;
    while (gate_open && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, gate_open}, 32'd0);
  endtask

  task automatic do_entry(input logic [2:0] pn);
    entry_req = 1'b1;
    park_number = pn;
    @(negedge clk);
    entry_req = 1'b0;
    @(negedge clk);
    wait_gate_close("entry_gate_close");
  endtask

  initial begin
    int cnt;
    int rej;
    int strb;

    do_reset();
    check("rst_bitmap", {24'd0, parking_capacity}, 32'h00);
    check("rst_free", {28'd0, free_count}, 32'd8);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_strobe", {31'd0, entry_strobe}, 32'd0);
    check("rst_gate", {31'd0, gate_open}, 32'd0);
    check("rst_assigned", {29'd0, assigned_space}, 32'd0);
    check("rst_pulses", {29'd0, entry_reject, alloc_error, exit_error}, 32'd0);

    // Single entry returning space 3
    entry_req = 1'b1;
    park_number = 3'd3;
    @(negedge clk);
    check("e1_strobe", {31'd0, entry_strobe}, 32'd1);
    check("e1_bitmap_pre", {24'd0, parking_capacity}, 32'h00);
    entry_req = 1'b0;
    @(negedge clk);
    check("e1_strobe_off", {31'd0, entry_strobe}, 32'd0);
    check("e1_bitmap", {24'd0, parking_capacity}, 32'h08);
    check("e1_assigned", {29'd0, assigned_space}, 32'd3);
    check("e1_free", {28'd0, free_count}, 32'd7);
    cnt = gate_open ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gate_open) cnt++;
      else break;
    end
    check("e1_gate_cycles", cnt, 32'd4);

    // Fill the park
    do_reset();
    for (int i = 0; i < 8; i++) do_entry(3'(i));
    check("fill_bitmap", {24'd0, parking_capacity}, 32'hFF);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_free", {28'd0, free_count}, 32'd0);
    check("fill_assigned", {29'd0, assigned_space}, 32'd7);

    // Entry on full park: reject every other cycle, no strobe
    entry_req = 1'b1;
    park_number = 3'd2;
    rej = 0;
    strb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (entry_reject) rej++;
      if (entry_strobe) strb++;
    end
    entry_req = 1'b0;
    check("reject_pulses", rej, 32'd3);
    check("reject_no_strobe", strb, 32'd0);
    check("reject_bitmap", {24'd0, parking_capacity}, 32'hFF);

    // Exit space 5 then re-admit into 5
    exit_req = 1'b1;
    exit_space = 3'd5;
    @(negedge clk);
    exit_req = 1'b0;
    check("exit5_bitmap", {24'd0, parking_capacity}, 32'hDF);
    check("exit5_free", {28'd0, free_count}, 32'd1);
    check("exit5_full", {31'd0, full}, 32'd0);
    check("exit5_err", {31'd0, exit_error}, 32'd0);
    do_entry(3'd5);
    check("readmit_bitmap", {24'd0, parking_capacity}, 32'hFF);
    check("readmit_assigned", {29'd0, assigned_space}, 32'd5);

    // Exit on empty park
    do_reset();
    exit_req = 1'b1;
    exit_space = 3'd2;
    @(negedge clk);
    exit_req = 1'b0;
    check("exit_err_pulse", {31'd0, exit_error}, 32'd1);
    check("exit_err_bitmap", {24'd0, parking_capacity}, 32'h00);
    @(negedge clk);
    check("exit_err_clear", {31'd0, exit_error}, 32'd0);

    // Allocation into an occupied space
    do_entry(3'd1);
    check("pre_allocerr_bitmap", {24'd0, parking_capacity}, 32'h02);
    entry_req = 1'b1;
    park_number = 3'd1;
    @(negedge clk);
    entry_req = 1'b0;
    check("allocerr_strobe", {31'd0, entry_strobe}, 32'd1);
    @(negedge clk);
    check("allocerr_pulse", {31'd0, alloc_error}, 32'd1);
    check("allocerr_gate", {31'd0, gate_open}, 32'd0);
    check("allocerr_bitmap", {24'd0, parking_capacity}, 32'h02);
    @(negedge clk);
    check("allocerr_clear", {31'd0, alloc_error}, 32'd0);
    check("allocerr_idle", {30'd0, gate_open, entry_strobe}, 32'd0);

    // Allocation of 4 and exit of 1 in the same ALLOC cycle
    entry_req = 1'b1;
    park_number = 3'd4;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req = 1'b1;
    exit_space = 3'd1;
    @(negedge clk);
    exit_req = 1'b0;
    check("simul_bitmap", {24'd0, parking_capacity}, 32'h10);
    check("simul_gate", {31'd0, gate_open}, 32'd1);
    check("simul_errs", {30'd0, alloc_error, exit_error}, 32'd0);
    wait_gate_close("simul_gate_close");

    // Same index: exit of 6 and allocation of 6 while 6 is free
    entry_req = 1'b1;
    park_number = 3'd6;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req = 1'b1;
    exit_space = 3'd6;
    @(negedge clk);
    exit_req = 1'b0;
    check("same_bitmap", {24'd0, parking_capacity}, 32'h50);
    check("same_errs", {30'd0, alloc_error, exit_error}, 32'd1);
    wait_gate_close("same_gate_close");

    // Async reset during GATE with bitmap 0F
    do_reset();
    for (int i = 0; i < 3; i++) do_entry(3'(i));
    entry_req = 1'b1;
    park_number = 3'd3;
    @(negedge clk);
    entry_req = 1'b0;
    @(negedge clk);
    check("pre_rst_bitmap", {24'd0, parking_capacity}, 32'h0F);
    check("pre_rst_gate", {31'd0, gate_open}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bitmap", {24'd0, parking_capacity}, 32'h00);
    check("arst_free", {28'd0, free_count}, 32'd8);
    check("arst_gate", {31'd0, gate_open}, 32'd0);
    check("arst_assigned", {29'd0, assigned_space}, 32'd0);
    check("arst_misc", {27'd0, entry_strobe, full, entry_reject, alloc_error, exit_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_gate", {31'd0, gate_open}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
